// File: rtl/pwm_audio_pkg.sv
// pwm_audio_pkg: shared defaults for the PWM sample player and its buffer.
package pwm_audio_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam logic [7:0] MIDSCALE_DEF = 8'h80;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-two sample buffer holding pointers, level and storage.
module sample_fifo
  import pwm_audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LW-1:0]     o_level
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  // Callers qualify i_wr/i_rd against full/empty, so the level cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= i_wr ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr <= i_rd ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_level  <= r_level + LW'(i_wr) - LW'(i_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_level == LW'(DEPTH);
  assign o_empty   = r_level == '0;
  assign o_level   = r_level;
endmodule

// File: rtl/pwm_sample_player.sv
// pwm_sample_player: buffers audio samples and plays one per tick_clk edge as PWM.
module pwm_sample_player
  import pwm_audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [DATA_W-1:0] MIDSCALE = MIDSCALE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick_clk,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        pwm_out,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  logic              r_s1, r_s2, r_s3;
  logic [DATA_W-1:0] r_cur_sample;
  logic [DATA_W-1:0] r_duty;
  logic [DATA_W-1:0] r_pwm_cnt;
  logic              r_pwm_out;
  logic              r_underrun;
  logic              w_tick, w_wr, w_rd, w_full, w_empty;
  logic [DATA_W-1:0] w_rd_data;
  assign w_tick  = r_s2 & ~r_s3;
  assign s_ready = ~rst & ~w_full;
  assign w_wr    = s_valid & s_ready;
  assign w_rd    = w_tick & ~w_empty;
  sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_wr),
    .i_wr_data (s_data),
    .i_rd      (w_rd),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fifo_level)
  );
  // Synchronizer presets high so a tick_clk already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1         <= 1'b1;
      r_s2         <= 1'b1;
      r_s3         <= 1'b1;
      r_cur_sample <= MIDSCALE;
      r_duty       <= MIDSCALE;
      r_pwm_cnt    <= '0;
      r_pwm_out    <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_s1         <= tick_clk;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_cur_sample <= w_rd ? w_rd_data : r_cur_sample;
      r_underrun   <= r_underrun | (w_tick & w_empty);
      r_pwm_cnt    <= r_pwm_cnt + 1'b1;
      r_duty       <= &r_pwm_cnt ? r_cur_sample : r_duty;
      r_pwm_out    <= r_pwm_cnt < r_duty;
    end
  end
  assign pwm_out  = r_pwm_out;
  assign underrun = r_underrun;
endmodule

// File: tb/tb_pwm_sample_player.sv
// tb_pwm_sample_player: random producer/tick traffic checked against a queue-based model.
module tb_pwm_sample_player;
  logic       clk = 1'b0;
  logic       rst, tick_clk, s_valid, s_ready, pwm_out, underrun;
  logic [7:0] s_data;
  logic [2:0] fifo_level;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] q[$];
  logic [7:0] m_cur, m_duty;
  bit         m_under, m_pwm, acc;
  bit         th[3];
  int         t;

  always #5 clk = ~clk;

  pwm_sample_player dut (
    .clk        (clk),
    .rst        (rst),
    .tick_clk   (tick_clk),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .pwm_out    (pwm_out),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: a tick is seen two edges after tick_clk is first sampled high;
  // PWM frame position is simply edges-since-reset modulo 256.
  task automatic model_step();
    bit tick;
    if (rst) begin
      q.delete();
      m_cur = 8'h80;
      m_duty = 8'h80;
      m_under = 0;
      m_pwm = 0;
      t = 0;
      th = '{1, 1, 1};
      acc = 0;
    end else begin
      tick = th[1] && !th[2];
      acc = s_valid && q.size() < 4;
      m_pwm = (t % 256) < m_duty;
      if (t % 256 == 255) m_duty = m_cur;
      t++;
      if (tick) begin
        if (q.size() > 0) m_cur = q.pop_front();
        else m_under = 1;
      end
      if (acc) q.push_back(s_data);
      th[2] = th[1];
      th[1] = th[0];
      th[0] = tick_clk;
    end
  endtask

  function automatic logic [7:0] pick();
    int k = $urandom_range(0, 3);
    return k == 0 ? 8'h00 : k == 1 ? 8'hFF : 8'($urandom);
  endfunction

  initial begin
    int half = 5;
    int seg;
    rst = 1'b1;
    tick_clk = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("fifo_level", int'(fifo_level), q.size());
      check("s_ready", int'(s_ready), int'(!rst && q.size() < 4));
      check("underrun", int'(underrun), int'(m_under));
      check("pwm_out", int'(pwm_out), int'(m_pwm));
      check("cur_sample", int'(dut.r_cur_sample), int'(m_cur));
      check("duty", int'(dut.r_duty), int'(m_duty));
      seg = (cyc / 1000) % 4;
      rst = cyc < 3 || $urandom_range(0, 799) == 0;
      half--;
      if (half == 0) begin
        tick_clk = ~tick_clk;
        half = $urandom_range(2, 10 + seg * 60);
      end
      if (!s_valid || acc) begin
        s_valid = $urandom_range(0, 99) < (seg == 0 ? 90 : seg == 1 ? 50 : seg == 2 ? 15 : 5);
        s_data = pick();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pwm_sample_player.md
PWM_SAMPLE_PLAYER -- requirements
Module: pwm_sample_player

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning sample width in bits and PWM resolution.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning sample buffer entries (power of two).
REQ-003 The block SHALL have parameter MIDSCALE, default 8'h80, meaning the held sample after reset.
REQ-004 The block SHALL have port clk  input  1  100 MHz system clock, the single clock of the block.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port tick_clk  input  1  16 kHz divided clock from the upstream clock divider, treated as data only.
REQ-007 The block SHALL have port s_data  input  DATA_W  sample offered by the producer.
REQ-008 The block SHALL have port s_valid  input  1  s_data is valid.
REQ-009 The block SHALL have port s_ready  output  1  buffer can accept a sample this cycle.
REQ-010 The block SHALL have port pwm_out  output  1  PWM audio bit.
REQ-011 The block SHALL have port underrun  output  1  sticky flag for a tick that found the buffer empty.
REQ-012 The block SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-013 tick_clk SHALL pass through three registers s1->s2->s3; tick = s2 & ~s3, a one-cycle pulse per tick_clk rising edge.
REQ-014 A tick SHALL never be used as a clock; all logic is clocked by clk only.
REQ-015 s_ready SHALL be 1 exactly when fifo_level < FIFO_DEPTH and rst is 0 (combinational from level).
REQ-016 A write SHALL occur on each clk edge where s_valid && s_ready; the producer holds s_data/s_valid until accepted.
REQ-017 On tick with fifo_level > 0 the oldest entry SHALL move into cur_sample, and level SHALL decrement.
REQ-018 On tick with fifo_level == 0, cur_sample SHALL hold its value and underrun SHALL set to 1.
REQ-019 underrun SHALL stay 1 until rst.
REQ-020 Simultaneous write and read SHALL both take effect, with level unchanged.
REQ-021 When the buffer is empty, a write and a tick in the same cycle SHALL store the write, log an underrun, and not bypass.
REQ-022 When the buffer is full, a tick SHALL free a slot only from the next cycle, because s_ready is 0 in the tick cycle.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH or go below 0.
REQ-024 pwm_cnt SHALL be a DATA_W-bit free-running counter that wraps 255->0, giving a 256-cycle frame of 390.625 kHz.
REQ-025 duty SHALL load cur_sample only in the cycle pwm_cnt == 255, so there are no mid-frame glitches.
REQ-026 pwm_out SHALL be registered: pwm_out <= (pwm_cnt < duty).
REQ-027 With duty 0, pwm_out SHALL be constantly low; with duty 255, it SHALL be high 255 of 256 cycles.
REQ-028 Latency from a tick_clk rising edge to the cur_sample update SHALL be 3 clk cycles; the new duty takes effect at the next frame boundary.

Reset
REQ-029 While rst=1, the following SHALL be cleared: fifo_level=0, pointers=0, underrun=0, pwm_out=0, pwm_cnt=0, s_ready=0.
REQ-030 While rst=1, cur_sample and duty SHALL be set to MIDSCALE.
REQ-031 While rst=1, s1/s2/s3 SHALL be set to 1, so that a tick_clk held high at reset release produces no tick.
REQ-032 Reset asserted mid-operation SHALL discard buffered samples and any tick in that cycle.

Structure
REQ-033 DATA_W, FIFO_DEPTH and MIDSCALE defaults SHALL live in a shared package, pwm_audio_pkg.
REQ-034 The buffer SHALL be one sub-module, sample_fifo, containing pointers, level, and storage.
REQ-035 The tick detector and PWM engine SHALL stay in the top module.

Verification
REQ-036 Reset release, tick_clk idle low, no writes -> pwm_out high for 128 of every 256 cycles, s_ready=1, underrun=0.
REQ-037 Write 0x40,0x00,0xFF, then 3 tick_clk edges at 6250-cycle half-period -> duty sequence 0x40 (64/256), 0x00 (always low), 0xFF (255/256); level 3->0.
REQ-038 Write 4 samples, hold s_valid with a 5th -> s_ready=0, level=4; on the next tick the 5th is accepted one cycle later, and level stays 4.
REQ-039 Empty buffer, tick_clk edge with a concurrent write of 0x10 -> underrun=1, cur_sample unchanged, level=1; the next tick loads 0x10.
REQ-040 tick_clk held high through reset release -> no tick until the following low-to-high transition; rst pulse with level=3 -> level=0, underrun=0, duty=0x80.
